// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: extension mode encodings and default widths shared by the immediate extender slice
package imm_ext_pkg;
  localparam logic [1:0] MODE_SIGN  = 2'b00;
  localparam logic [1:0] MODE_ZERO  = 2'b01;
  localparam logic [1:0] MODE_BR    = 2'b10;
  localparam logic [1:0] MODE_UPPER = 2'b11;
  localparam int DEF_IN_W  = 16;
  localparam int DEF_OUT_W = 32;
  localparam int DEF_DEPTH = 2;
  typedef logic [1:0] mode_t;
endpackage

// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if: decode-side push and ALU-side pop handshakes of the immediate extender
//   in_valid/in_ready/in_imm/in_mode : immediate and mode offered by decode
//   out_valid/out_ready/out_data     : extended result at FIFO head
//   occupancy                        : entries currently buffered
interface imm_extend_pipe_if #(
  parameter int IN_W  = imm_ext_pkg::DEF_IN_W,
  parameter int OUT_W = imm_ext_pkg::DEF_OUT_W,
  parameter int DEPTH = imm_ext_pkg::DEF_DEPTH
);
  logic                     in_valid;
  logic                     in_ready;
  logic [IN_W-1:0]          in_imm;
  logic [1:0]               in_mode;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_data;
  logic [$clog2(DEPTH):0]   occupancy;
  modport master (output in_valid, in_imm, in_mode, out_ready,
                  input  in_ready, out_valid, out_data, occupancy);
  modport slave  (input  in_valid, in_imm, in_mode, out_ready,
                  output in_ready, out_valid, out_data, occupancy);
endinterface

// File: rtl/ext_fifo.sv
// ext_fifo: synchronous FIFO with occupancy count; storage cleared on reset
//   clk, rst_n        : clock, async active-low reset
//   i_push, i_wdata   : write request and data (ignored when full)
//   i_pop, o_rdata    : read request (ignored when empty) and head entry
//   o_occ, o_full, o_empty : fill level and derived flags
module ext_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_occ,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr];
  assign o_occ   = r_cnt;
  // pointers are exactly AW bits, so the increment wraps modulo DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: extends an immediate in one of four modes and buffers results in a FIFO
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of imm_extend_pipe_if (push handshake in, pop handshake out)
module imm_extend_pipe import imm_ext_pkg::*; #(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic               clk,
  input logic               rst_n,
  imm_extend_pipe_if.slave  bus
);
  if (OUT_W <= IN_W + 2 || IN_W < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $fatal(1, "imm_extend_pipe: illegal IN_W/OUT_W/DEPTH");
  end
  logic [IN_W-1:0]  w_imm;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_br;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_ext;
  logic             w_full;
  logic             w_empty;
  assign w_imm   = bus.in_imm;
  assign w_sext  = {{(OUT_W-IN_W){w_imm[IN_W-1]}}, w_imm};
  assign w_zext  = {{(OUT_W-IN_W){1'b0}}, w_imm};
  // OUT_W > IN_W+2 keeps the sign bit inside the word after the shift
  assign w_br    = w_sext << 2;
  assign w_upper = {w_imm, {(OUT_W-IN_W){1'b0}}};
  assign w_ext   = bus.in_mode == MODE_SIGN ? w_sext :
                   bus.in_mode == MODE_ZERO ? w_zext :
                   bus.in_mode == MODE_BR   ? w_br   : w_upper;
  // handshakes depend on registered fill level only, never on out_ready
  assign bus.in_ready  = !w_full;
  assign bus.out_valid = !w_empty;
  ext_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.in_valid),
    .i_pop   (bus.out_ready),
    .i_wdata (w_ext),
    .o_rdata (bus.out_data),
    .o_occ   (bus.occupancy),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
endmodule
